// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial operand front end.
package serial_pkg;

  localparam int unsigned SERIAL_WIDTH = 8;
  localparam int unsigned SERIAL_LW    = $clog2(SERIAL_WIDTH + 1);

  // One operand pair plus its bit length, at the default width.
  typedef struct packed {
    logic [SERIAL_WIDTH-1:0] a;
    logic [SERIAL_WIDTH-1:0] b;
    logic [SERIAL_LW-1:0]    len;
  } serial_word_t;

  // A length of 0 or anything above the operand width means "full width".
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/serial_operand_slot.sv
// Single-word holding register: operand pair, length and a full flag.
module serial_operand_slot #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] a_d,
  input  logic [WIDTH-1:0] b_d,
  input  logic [LW-1:0]    len_d,
  output logic             full,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [LW-1:0]    len_q
);

  // Load wins over clear so a drain and refill in one cycle keeps the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      len_q <= '0;
    end else if (load) begin
      full  <= 1'b1;
      a_q   <= a_d;
      b_q   <= b_d;
      len_q <= len_d;
    end else if (clear) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial front end for the bit-serial adder: LSB-first bit pairs
// with a one-word pending buffer for gapless back-to-back words.
module serial_operand_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH,
  parameter int unsigned LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [LW-1:0]    len_in,
  input  logic             stall,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last
);

  logic             busy, busy_n;
  logic [LW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sh_a, sh_a_n;
  logic [WIDTH-1:0] sh_b, sh_b_n;

  logic             pend_full, pend_load, pend_clr;
  logic [WIDTH-1:0] pend_a, pend_b;
  logic [LW-1:0]    pend_len;

  logic             accept;
  logic [LW-1:0]    in_len;

  // Handshake and serial outputs, all derived from registered state.
  assign up_ready = !pend_full && !rst;
  assign accept   = up_valid && up_ready;
  assign in_len   = LW'(norm_len(32'(len_in), WIDTH));
  assign vld      = busy && !stall && !rst;
  assign a        = vld && sh_a[0];
  assign b        = vld && sh_b[0];
  assign last     = vld && (cnt == LW'(1));

  serial_operand_slot #(
    .WIDTH (WIDTH),
    .LW    (LW)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .load  (pend_load),
    .clear (pend_clr),
    .a_d   (a_in),
    .b_d   (b_in),
    .len_d (in_len),
    .full  (pend_full),
    .a_q   (pend_a),
    .b_q   (pend_b),
    .len_q (pend_len)
  );

  // Active-slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      sh_a <= '0;
      sh_b <= '0;
    end else begin
      busy <= busy_n;
      cnt  <= cnt_n;
      sh_a <= sh_a_n;
      sh_b <= sh_b_n;
    end
  end

  // Next active state and pending-slot control: shift, refill on last, or park.
  always_comb begin
    busy_n    = busy;
    cnt_n     = cnt;
    sh_a_n    = sh_a;
    sh_b_n    = sh_b;
    pend_load = 1'b0;
    pend_clr  = 1'b0;

    if (last) begin
      if (pend_full) begin
        sh_a_n    = pend_a;
        sh_b_n    = pend_b;
        cnt_n     = pend_len;
        pend_clr  = 1'b1;
        pend_load = accept;
      end else if (accept) begin
        sh_a_n = a_in;
        sh_b_n = b_in;
        cnt_n  = in_len;
      end else begin
        busy_n = 1'b0;
      end
    end else begin
      if (vld) begin
        sh_a_n = sh_a >> 1;
        sh_b_n = sh_b >> 1;
        cnt_n  = cnt - LW'(1);
      end
      if (accept) begin
        if (busy) begin
          pend_load = 1'b1;
        end else begin
          busy_n = 1'b1;
          sh_a_n = a_in;
          sh_b_n = b_in;
          cnt_n  = in_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench for serial_operand_serializer with a word scoreboard and a
// serial-adder reference on the output side.
module tb_serial_operand_serializer;
  import serial_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] a_in, b_in;
  logic [3:0] len_in;
  logic       stall;
  logic       vld, a, b, last;

  int errors = 0;
  int checks = 0;

  serial_word_t wq[$];
  serial_word_t cur;
  bit           have_cur = 1'b0;
  int           idx = 0;
  bit           carry = 1'b0;
  int           sum_acc = 0;

  serial_operand_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .len_in   (len_in),
    .stall    (stall),
    .vld      (vld),
    .a        (a),
    .b        (b),
    .last     (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nlen(input logic [3:0] l);
    return ((l == 0) || (l > 4'd8)) ? 8 : int'(l);
  endfunction

  // Output monitor: compare each valid bit pair and the serial sum per word.
  always @(negedge clk) begin
    if (rst) begin
      wq.delete();
      have_cur = 1'b0;
      carry    = 1'b0;
    end else if (vld) begin
      if (!have_cur) begin
        chk("vld_with_queued_word", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          cur      = wq.pop_front();
          have_cur = 1'b1;
          idx      = 0;
          sum_acc  = 0;
          carry    = 1'b0;
        end
      end
      if (have_cur) begin
        int  n;
        bit  s;
        n = nlen(cur.len);
        chk("a_bit", 32'(a), 32'(cur.a[idx]));
        chk("b_bit", 32'(b), 32'(cur.b[idx]));
        chk("last_flag", 32'(last), 32'(idx == n - 1));
        s       = a ^ b ^ carry;
        carry   = (a & b) | (a & carry) | (b & carry);
        sum_acc = sum_acc | (int'(s) << idx);
        idx++;
        if (idx >= n) begin
          chk("adder_sum", 32'(sum_acc),
              32'((int'(cur.a) + int'(cur.b)) & ((1 << n) - 1)));
          have_cur = 1'b0;
          carry    = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [3:0] tl);
    serial_word_t w;
    bit acc;
    acc      = 1'b0;
    a_in     = ta;
    b_in     = tb_v;
    len_in   = tl;
    up_valid = 1'b1;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = up_ready;
      @(posedge clk);
    end
    chk("accept_in_time", 32'(acc), 32'd1);
    if (acc) begin
      w.a   = ta;
      w.b   = tb_v;
      w.len = tl;
      wq.push_back(w);
    end
    #1 up_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (wq.size() != 0 || have_cur || vld); k++)
      @(negedge clk);
    chk("drained", 32'(wq.size()) + 32'(have_cur), 32'd0);
    step();
  endtask

  initial begin
    rst      = 1'b1;
    up_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
    len_in   = '0;
    stall    = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_outputs", 32'({vld, a, b, last, up_ready}), 32'd0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'({vld, up_ready}), 32'b01);
    step();

    // Single full-width word
    send(8'h35, 8'h0F, 4'd8);
    drain();

    // Three back-to-back words: gapless run and pending backpressure
    fork
      begin
        send(8'hFF, 8'h01, 4'd8);
        send(8'h12, 8'h34, 4'd8);
        send(8'h80, 8'h80, 4'd8);
      end
      begin
        @(negedge clk);
        for (int k = 0; k < 50 && !vld; k++) @(negedge clk);
        for (int i = 1; i <= 24; i++) begin
          chk("b2b_vld", 32'(vld), 32'd1);
          chk("b2b_ready", 32'(up_ready), 32'((i == 1) || (i == 9) || (i >= 17)));
          @(negedge clk);
        end
        chk("b2b_vld_after_run", 32'(vld), 32'd0);
      end
    join
    drain();

    // Short and normalized lengths
    send(8'hFD, 8'h00, 4'd3);
    drain();
    send(8'hFD, 8'h00, 4'd0);
    drain();
    send(8'hFD, 8'h00, 4'd9);
    drain();

    // Stall on bit 2 and on the last bit
    send(8'hA7, 8'h5C, 4'd8);
    step();
    step();
    stall = 1'b1;
    @(negedge clk);
    chk("stall_bit2_vld", 32'({vld, last}), 32'd0);
    step();
    stall = 1'b0;
    repeat (5) step();
    stall = 1'b1;
    @(negedge clk);
    chk("stall_last_vld", 32'({vld, last}), 32'd0);
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("last_after_stall", 32'({vld, last}), 32'b11);
    drain();

    // Reset mid-word with pending full, then a fresh word
    send(8'h5A, 8'h33, 4'd8);
    send(8'hC3, 8'h3C, 4'd8);
    step();
    step();
    @(negedge clk);
    chk("pending_full_ready", 32'(up_ready), 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("in_reset_outputs", 32'({vld, up_ready}), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", 32'({vld, up_ready}), 32'b01);
    step();
    send(8'h9C, 8'h77, 4'd8);
    drain();

    // Idle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({vld, a, b, last, up_ready}), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
